// File: rtl/apb_completer_pkg.sv
// Shared types, widths and the byte-lane merge helper for the APB4 register completer.
package apb_completer_pkg;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_state_e;

    localparam int REG_W  = 32;
    localparam int STRB_W = 4;

    function automatic logic [REG_W-1:0] apply_strb(input logic [REG_W-1:0]  old_val,
                                                    input logic [REG_W-1:0]  wdata,
                                                    input logic [STRB_W-1:0] strb);
        logic [REG_W-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Access-phase wait counter: loaded at setup, counts down while the access is held, flags zero.
module apb_wait_counter #(
    parameter int unsigned MAX_VAL = 1,
    localparam int unsigned CNT_W  = (MAX_VAL < 1) ? 1 : $clog2(MAX_VAL + 1)
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(MAX_VAL);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb4_reg_completer.sv
// APB4 completer with a bank of 32-bit registers; the top index is a read-only write counter.
// Optional build macro APB_COMPLETER_PROT_EN adds PPROT-based secure/privilege error checks.
module apb4_reg_completer
    import apb_completer_pkg::*;
#(
    parameter int unsigned          NUM_REGS    = 8,
    parameter int unsigned          WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0]  SECURE_MASK = NUM_REGS'(8'h01)
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [31:0]               PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic [STRB_W-1:0]         PSTRB,
    input  logic [2:0]                PPROT,
    output logic [REG_W-1:0]          PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [NUM_REGS*REG_W-1:0] reg_q,
    output logic [0:0]                state_dbg
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_ACCESS = ACCESS;

    // Handshake: PSEL qualifies a transfer, PENABLE marks its access phase, and the
    // transfer completes on the rising edge where PSEL, PENABLE and PREADY are all high.

    logic [0:0]        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [REG_W-1:0]  wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [REG_W-1:0]  regs_q [NUM_REGS-1];
    logic [REG_W-1:0]  regs_d [NUM_REGS-1];
    logic [REG_W-1:0]  wr_cnt_q, wr_cnt_d;

    logic             load, dec, cnt_zero, done;
    logic [IDX_W-1:0] idx;
    logic             oob_err, align_err, ro_err, prot_err, err;

    assign load = (state_q == ST_IDLE)   && PSEL && !PENABLE;
    assign dec  = (state_q == ST_ACCESS) && PSEL &&  PENABLE && !cnt_zero;
    assign done = (state_q == ST_ACCESS) && PSEL &&  PENABLE &&  cnt_zero;

    apb_wait_counter #(.MAX_VAL(WAIT_STATES)) u_wait (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .load    (load),
        .dec     (dec),
        .zero    (cnt_zero)
    );

    // Decode looks only at the address latched in the setup phase.
    assign idx       = addr_q[IDX_W+1:2];
    assign oob_err   = ({2'b00, addr_q[31:2]} >= 32'(NUM_REGS));
    assign align_err = (addr_q[1:0] != 2'b00);
    assign ro_err    = write_q && (idx == IDX_W'(NUM_REGS - 1));

`ifdef APB_COMPLETER_PROT_EN
    logic [1:0] prot_q, prot_d;
    logic       unused_prot;
    assign unused_prot = PPROT[2];
    assign prot_err = (!oob_err && prot_q[1] && SECURE_MASK[idx]) || (write_q && !prot_q[0]);
`else
    logic unused_prot;
    assign unused_prot = ^{PPROT, SECURE_MASK};
    assign prot_err    = 1'b0;
`endif

    assign err = oob_err || align_err || ro_err || prot_err;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        strb_d  = strb_q;
`ifdef APB_COMPLETER_PROT_EN
        prot_d  = prot_q;
`endif
        if (state_q == ST_IDLE) begin
            if (load) begin
                state_d = ST_ACCESS;
                addr_d  = PADDR;
                wdata_d = PWDATA;
                write_d = PWRITE;
                strb_d  = PSTRB;
`ifdef APB_COMPLETER_PROT_EN
                prot_d  = PPROT[1:0];
`endif
            end
        end else if (!PSEL || done) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (done && write_q && !err) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (idx == IDX_W'(i)) regs_d[i] = apply_strb(regs_q[i], wdata_q, strb_q);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            strb_q   <= '0;
            wr_cnt_q <= '0;
            for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            strb_q   <= strb_d;
            wr_cnt_q <= wr_cnt_d;
            for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= regs_d[i];
        end
    end

`ifdef APB_COMPLETER_PROT_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) prot_q <= '0;
        else          prot_q <= prot_d;
    end
`endif

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS - 1; i++) reg_q[REG_W*i +: REG_W] = regs_q[i];
        reg_q[REG_W*(NUM_REGS-1) +: REG_W] = wr_cnt_q;
    end

    assign PREADY    = done;
    assign PSLVERR   = done && err;
    assign PRDATA    = (done && !write_q && !err) ? reg_q[REG_W*idx +: REG_W] : '0;
    assign state_dbg = state_q;

endmodule
